seq_multiplier: RTL and testbench

- Multi-cycle, handshaked successor to the combinational scalar multiplier in the scalar ALU.
- Supports signed and unsigned operands and returns the full 2N-bit product.
- Computes the product with a radix-2 shift-add datapath on operand magnitudes, then applies a final sign-correction cycle.
- Sits beside the combinational ALU ops. The scalar pipeline stalls on in_ready/out_valid, which avoids the N-bit array multiplier timing path.

---
 rtl/seq_multiplier.sv | 127 ++++++++++++
 tb/tb_seq_multiplier.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Multi-cycle signed/unsigned multiplier: radix-2 shift-add on operand magnitudes,
// then one sign-correction cycle, with valid/ready handshakes on both sides.
module seq_multiplier #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         z_flag,
    output logic         n_flag,
    output logic         c_flag,
    output logic         v_flag
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    localparam int CW = $clog2(N + 1);

    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic s);
        return (s && x[N-1]) ? (~x + {{(N-1){1'b0}}, 1'b1}) : x;
    endfunction

    function automatic logic [2*N-1:0] negate2n(input logic [2*N-1:0] x);
        return ~x + {{(2*N-1){1'b0}}, 1'b1};
    endfunction

    state_t         r_state;
    state_t         w_next;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic           r_signed;
    logic [N-1:0]   r_result;
    logic [N-1:0]   r_result_hi;
    logic           r_z;
    logic           r_n;
    logic           r_c;
    logic           r_v;

    logic           w_accept;
    logic           w_last;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_lo;
    logic [N-1:0]   w_hi;

    assign w_accept = (r_state == IDLE) && in_valid;
    // The counter reaches N one cycle after the last add; that spare BUSY cycle
    // does no arithmetic and sets the accept-to-valid latency to N+2.
    assign w_last   = (r_cnt == CW'(N));
    assign w_prod   = r_neg ? negate2n(r_acc) : r_acc;
    assign w_lo     = w_prod[N-1:0];
    assign w_hi     = w_prod[2*N-1:N];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign z_flag    = r_z;
    assign n_flag    = r_n;
    assign c_flag    = r_c;
    assign v_flag    = r_v;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid)  w_next = BUSY;
            BUSY: if (w_last)    w_next = FIX;
            FIX:                 w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default:             w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_signed    <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= {{N{1'b0}}, magnitude(a, is_signed)};
                r_mplier <= magnitude(b, is_signed);
                r_neg    <= is_signed & (a[N-1] ^ b[N-1]);
                r_signed <= is_signed;
                r_acc    <= '0;
                r_cnt    <= '0;
            end
            if (r_state == BUSY && !w_last) begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (r_state == FIX) begin
                r_result    <= w_lo;
                r_result_hi <= w_hi;
                r_z         <= (w_lo == '0);
                r_n         <= w_lo[N-1];
                r_c         <= !r_signed && (w_hi != '0);
                r_v         <= r_signed && (w_hi != {N{w_lo[N-1]}});
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: hand-computed vector table, backpressure and reset
// sequences, and random operations against an arithmetic product model.
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [7:0]  a, b, result, result_hi;
    logic        z_flag, n_flag, c_flag, v_flag;

    logic        rst32, in_valid32, in_ready32, is_signed32, out_valid32, out_ready32;
    logic [31:0] a32, b32, result32, result_hi32;
    logic        z32, n32, c32, v32;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .z_flag(z_flag), .n_flag(n_flag), .c_flag(c_flag), .v_flag(v_flag)
    );

    seq_multiplier #(.N(32)) dut32 (
        .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .is_signed(is_signed32), .out_valid(out_valid32),
        .out_ready(out_ready32), .result(result32), .result_hi(result_hi32),
        .z_flag(z32), .n_flag(n32), .c_flag(c32), .v_flag(v32)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         s;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [3:0] f;   // {z, n, c, v}
    } vec_t;

    vec_t tbl[10];

    // Full product of two n-bit operands as plain integer arithmetic (n = 8 or 32).
    function automatic logic [63:0] ref_prod(input int n, input logic [63:0] x,
                                             input logic [63:0] y, input bit s);
        logic [63:0] opm, ex, ey, pm;
        opm = (64'd1 << n) - 64'd1;
        pm  = (n == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * n)) - 64'd1);
        ex  = x & opm;
        ey  = y & opm;
        if (s && ((ex >> (n - 1)) & 64'd1) == 64'd1) ex = ex | ~opm;
        if (s && ((ey >> (n - 1)) & 64'd1) == 64'd1) ey = ey | ~opm;
        return (ex * ey) & pm;
    endfunction

    function automatic logic [3:0] ref_flags(input int n, input logic [63:0] p, input bit s);
        logic [63:0] opm, lo, hi;
        logic z, ng, c, v;
        opm = (64'd1 << n) - 64'd1;
        lo  = p & opm;
        hi  = (p >> n) & opm;
        z   = (lo == 64'd0);
        ng  = ((lo >> (n - 1)) & 64'd1) == 64'd1;
        c   = !s && (hi != 64'd0);
        v   = s && (hi != (ng ? opm : 64'd0));
        return {z, ng, c, v};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input bit ts, output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        a = ta; b = tb_; is_signed = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin lat = c; break; end
            @(negedge clk);
        end
    endtask

    task automatic release8(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, "_drop"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    task automatic op32(input logic [31:0] ta, input logic [31:0] tb_, input bit ts, output int lat);
        int k;
        k = 0;
        while (!in_ready32 && k < 100) begin @(negedge clk); k++; end
        a32 = ta; b32 = tb_; is_signed32 = ts; in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        a32 = $urandom; b32 = $urandom; is_signed32 = 1'($urandom);
        lat = -1;
        for (int c = 0; c < 80; c++) begin
            if (out_valid32) begin lat = c; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [63:0] p;
        logic [3:0]  f;
        logic [7:0]  ra, rb;
        bit          rs;

        tbl[0] = '{8'h0F, 8'h11, 1'b0, 8'hFF, 8'h00, 4'b0100};
        tbl[1] = '{8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 4'b0010};
        tbl[2] = '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 4'b0101};
        tbl[3] = '{8'hFD, 8'h05, 1'b1, 8'hF1, 8'hFF, 4'b0100};
        tbl[4] = '{8'h00, 8'h5A, 1'b0, 8'h00, 8'h00, 4'b1000};
        tbl[5] = '{8'h7F, 8'h7F, 1'b1, 8'h01, 8'h3F, 4'b0001};
        tbl[6] = '{8'h80, 8'h80, 1'b1, 8'h00, 8'h40, 4'b1001};
        tbl[7] = '{8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 4'b1010};
        tbl[8] = '{8'hFB, 8'h00, 1'b1, 8'h00, 8'h00, 4'b1000};
        tbl[9] = '{8'hFF, 8'h01, 1'b1, 8'hFF, 8'hFF, 4'b0100};

        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        rst32 = 1'b0; in_valid32 = 1'b0; a32 = '0; b32 = '0; is_signed32 = 1'b0; out_ready32 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hs8", {62'd0, in_ready, out_valid}, 64'b10);
        check("reset_out8", {44'd0, result, result_hi, z_flag, n_flag, c_flag, v_flag}, 64'd0);
        rst = 1'b1; rst32 = 1'b1;
        @(negedge clk);

        // Hand-computed vectors
        for (int i = 0; i < 10; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].s, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd10);
            check($sformatf("vec%0d_result", i), {56'd0, result}, {56'd0, tbl[i].lo});
            check($sformatf("vec%0d_result_hi", i), {56'd0, result_hi}, {56'd0, tbl[i].hi});
            check($sformatf("vec%0d_flags", i), {60'd0, z_flag, n_flag, c_flag, v_flag}, {60'd0, tbl[i].f});
            release8($sformatf("vec%0d", i));
        end

        // Backpressure: outputs hold, in_ready stays low, a stray in_valid is dropped
        op8(8'h0F, 8'h11, 1'b0, lat);
        check("bp_latency", 64'(lat), 64'd10);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin a = 8'h33; b = 8'h44; is_signed = 1'b0; in_valid = 1'b1; end
            else in_valid = 1'b0;
            check($sformatf("bp_hold%0d", c),
                  {42'd0, in_ready, out_valid, result, result_hi, z_flag, n_flag, c_flag, v_flag},
                  {42'd0, 1'b0, 1'b1, 8'hFF, 8'h00, 4'b0100});
            @(negedge clk);
        end
        in_valid = 1'b0;
        release8("bp");
        check("bp_retain", {48'd0, result, result_hi}, {48'd0, 8'hFF, 8'h00});
        repeat (15) @(negedge clk);
        check("bp_no_queue", {62'd0, in_ready, out_valid}, 64'b10);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            if (i < 4) begin ra = (i[0]) ? 8'h80 : 8'h7F; rb = (i[1]) ? 8'h80 : 8'hFF; end
            p = ref_prod(8, {56'd0, ra}, {56'd0, rb}, rs);
            f = ref_flags(8, p, rs);
            op8(ra, rb, rs, lat);
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd10);
            check($sformatf("rnd%0d_product a=%h b=%h s=%0d", i, ra, rb, rs),
                  {48'd0, result_hi, result}, p);
            check($sformatf("rnd%0d_flags", i), {60'd0, z_flag, n_flag, c_flag, v_flag}, {60'd0, f});
            release8($sformatf("rnd%0d", i));
        end

        // 32-bit: load nonzero outputs, then abort an operation with reset
        op32(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, lat);
        p = ref_prod(32, 64'hFFFF_FFFF, 64'd2, 1'b0);
        check("w32_latency", 64'(lat), 64'd34);
        check("w32_product", {result_hi32, result32}, p);
        check("w32_flags", {60'd0, z32, n32, c32, v32}, {60'd0, ref_flags(32, p, 1'b0)});
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;
        a32 = 32'h1234_5678; b32 = 32'h0000_0009; is_signed32 = 1'b0; in_valid32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        repeat (3) @(negedge clk);
        check("w32_busy", {62'd0, in_ready32, out_valid32}, 64'b00);
        rst32 = 1'b0;
        @(negedge clk);
        rst32 = 1'b1;
        check("w32_reset_hs", {62'd0, in_ready32, out_valid32}, 64'b10);
        check("w32_reset_out", {result_hi32, result32}, 64'd0);
        check("w32_reset_flags", {60'd0, z32, n32, c32, v32}, 64'd0);
        repeat (40) @(negedge clk);
        check("w32_abort_no_output", {63'd0, out_valid32}, 64'd0);

        op32(32'h0000_0000, 32'h1234_5678, 1'b0, lat);
        check("w32_zero_latency", 64'(lat), 64'd34);
        check("w32_zero_product", {result_hi32, result32}, 64'd0);
        check("w32_zero_flags", {60'd0, z32, n32, c32, v32}, 64'b1000);
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;

        op32(32'h8000_0000, 32'h8000_0000, 1'b1, lat);
        p = ref_prod(32, 64'h8000_0000, 64'h8000_0000, 1'b1);
        check("w32_minmin_product", {result_hi32, result32}, p);
        check("w32_minmin_flags", {60'd0, z32, n32, c32, v32}, {60'd0, ref_flags(32, p, 1'b1)});
        out_ready32 = 1'b1;
        @(negedge clk);
        out_ready32 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
